// File: rtl/des_f_sbox_round.sv
// DES round f-function: key mix, eight S-boxes evaluated LANES at a time, then the P permutation.
// Valid/ready on both sides; a single operand is in flight at a time.
module des_f_sbox_round #(
  parameter int LANES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] expand_data,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);

  localparam int NCYC = 8 / LANES;
  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [47:0]         x_r;
  logic [31:0]         s_acc_r;
  logic [31:0]         f_out_r;
  logic                out_valid_r;
  logic [4*LANES-1:0]  nib_s;
  logic [31:0]         s_next_s;

  // One S-box row is packed as 16 nibbles, column 0 in the most significant nibble.
  function automatic logic [3:0] sbox(input logic [2:0] sel, input logic [5:0] b);
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] line;
    row  = {b[5], b[0]};
    col  = b[4:1];
    line = 64'h0;
    case ({sel, row})
      5'd0:  line = 64'hE4D12FB83A6C5907;
      5'd1:  line = 64'h0F74E2D1A6CB9538;
      5'd2:  line = 64'h41E8D62BFC973A50;
      5'd3:  line = 64'hFC8249175B3EA06D;
      5'd4:  line = 64'hF18E6B34972DC05A;
      5'd5:  line = 64'h3D47F28EC01A69B5;
      5'd6:  line = 64'h0E7BA4D158C6932F;
      5'd7:  line = 64'hD8A13F42B67C05E9;
      5'd8:  line = 64'hA09E63F51DC7B428;
      5'd9:  line = 64'hD709346A285ECBF1;
      5'd10: line = 64'hD6498F30B12C5AE7;
      5'd11: line = 64'h1AD069874FE3B52C;
      5'd12: line = 64'h7DE3069A1285BC4F;
      5'd13: line = 64'hD8B56F03472C1AE9;
      5'd14: line = 64'hA690CB7DF13E5284;
      5'd15: line = 64'h3F06A1D8945BC72E;
      5'd16: line = 64'h2C417AB6853FD0E9;
      5'd17: line = 64'hEB2C47D150FA3986;
      5'd18: line = 64'h421BAD78F9C5630E;
      5'd19: line = 64'hB8C71E2D6F09A453;
      5'd20: line = 64'hC1AF92680D34E75B;
      5'd21: line = 64'hAF427C9561DE0B38;
      5'd22: line = 64'h9EF528C3704A1DB6;
      5'd23: line = 64'h432C95FABE17608D;
      5'd24: line = 64'h4B2EF08D3C975A61;
      5'd25: line = 64'hD0B7491AE35C2F86;
      5'd26: line = 64'h14BDC37EAF680592;
      5'd27: line = 64'h6BD814A7950FE23C;
      5'd28: line = 64'hD2846FB1A93E50C7;
      5'd29: line = 64'h1FD8A374C56B0E92;
      5'd30: line = 64'h7B419CE206ADF358;
      5'd31: line = 64'h21E74A8DFC90356B;
      default: line = 64'h0;
    endcase
    sbox = line[(6'd60 - {col, 2'b00}) +: 4];
  endfunction

  // DES bit j lives at vector index 32-j, so each term is s[32 - P[i]].
  function automatic logic [31:0] p_perm(input logic [31:0] s);
    p_perm = {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
              s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
              s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
              s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  // Lane lookups: lane i handles S-box cnt*LANES+i from the top groups of x_r.
  always_comb begin
    nib_s = '0;
    for (int i = 0; i < LANES; i++) begin
      nib_s[4*(LANES-1-i) +: 4] = sbox(3'((int'(cnt_r) * LANES) + i), x_r[47-6*i -: 6]);
    end
  end

  // Shift-accumulate keeps the lower-numbered S-box in the more significant nibble.
  always_comb begin
    s_next_s = (s_acc_r << (4 * LANES)) | 32'(nib_s);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      x_r         <= 48'h0;
      s_acc_r     <= 32'h0;
      f_out_r     <= 32'h0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r     <= expand_data ^ subkey;
            cnt_r   <= '0;
            s_acc_r <= 32'h0;
            state_r <= CALC;
          end
        end
        CALC: begin
          x_r     <= x_r << (6 * LANES);
          s_acc_r <= s_next_s;
          cnt_r   <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            f_out_r     <= p_perm(s_next_s);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE) && !Reset;
  assign out_valid = out_valid_r;
  assign f_out     = f_out_r;

endmodule

// File: tb/tb_des_f_sbox_round.sv
// Scoreboard bench: four instances (LANES 1,2,4,8) share stimulus; each has its own
// expected-result queue filled from a table-driven f-function model.
module tb_des_f_sbox_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [47:0] expand_data;
  logic [47:0] subkey;
  logic        out_ready;
  logic [32:0] force_exp;
  logic [3:0]  busy_v;
  logic [3:0]  ov_v;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] ref_f(input logic [47:0] x);
    logic [31:0] s;
    logic [31:0] f;
    int g, row, col;
    s = 32'h0;
    for (int k = 0; k < 8; k++) begin
      g   = int'((x >> (42 - 6*k)) & 48'h3F);
      row = ((g >> 5) & 1) * 2 + (g & 1);
      col = (g >> 1) & 15;
      s[31-4*k -: 4] = 4'(SB[k][row*16 + col]);
    end
    f = 32'h0;
    for (int i = 1; i <= 32; i++) f[32-i] = s[32-PT[i-1]];
    return f;
  endfunction

  task automatic check(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lanes=%0d t=%0t got=%h want=%h", nm, ln, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int LN = 1 << gi;
    localparam int NC = 8 / LN;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] f_out;
    logic [31:0] q[$];
    bit          busy = 1'b0;
    bit          started = 1'b0;
    bit          rst_seen = 1'b0;
    int          age = 0;

    des_f_sbox_round #(.LANES(LN)) dut (
      .Clk(clk), .Reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .expand_data(expand_data), .subkey(subkey),
      .out_valid(out_valid), .out_ready(out_ready),
      .f_out(f_out)
    );

    assign busy_v[gi] = busy;
    assign ov_v[gi]   = out_valid;

    // Input side: push expected result on accept, pop on output handshake.
    initial forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        busy     = 1'b0;
        rst_seen = 1'b1;
      end else begin
        rst_seen = 1'b0;
        if (busy && out_valid && out_ready && age >= NC) begin
          void'(q.pop_front());
          busy = 1'b0;
        end
        if (busy && age < 1000) age++;
        if (in_valid && in_ready) begin
          q.push_back(force_exp[32] ? force_exp[31:0] : ref_f(expand_data ^ subkey));
          busy = 1'b1;
          age  = 0;
        end
      end
      started = 1'b1;
    end

    // Output side: handshake flags every cycle, result whenever it should be presented.
    initial forever begin
      @(negedge clk);
      if (started) begin
        check("in_ready", LN, 32'(in_ready), 32'(!reset && !busy));
        check("out_valid", LN, 32'(out_valid), 32'(busy && age >= NC));
        if (rst_seen) check("f_out_reset", LN, f_out, 32'h0);
        else if (busy && age >= NC && q.size() != 0) check("f_out", LN, f_out, q[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy_v != 4'h0 && t < 100) begin
      step();
      t++;
    end
    check(nm, 0, 32'(busy_v), 32'h0);
  endtask

  task automatic issue(input logic [47:0] e, input logic [47:0] k, input logic [31:0] known);
    wait_idle("idle_wait");
    expand_data = e;
    subkey      = k;
    force_exp   = {1'b1, known};
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    force_exp   = 33'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset       = 1'b1;
    in_valid    = 1'b1;
    expand_data = {16'($urandom), $urandom};
    subkey      = {16'($urandom), $urandom};
    out_ready   = 1'b1;
    force_exp   = 33'h0;
    repeat (2) step();
    reset    = 1'b0;
    in_valid = 1'b0;
    step();

    issue(48'h0, 48'h0, 32'hD8D8DBBC);
    wait_idle("drain_zero");
    issue(48'h7A15557A1555, 48'h1B02EFFC7072, 32'h234AA9BB);
    wait_idle("drain_fips");

    // Backpressure: results must sit still until out_ready.
    out_ready = 1'b0;
    issue(48'h7A15557A1555, 48'h1B02EFFC7072, 32'h234AA9BB);
    t = 0;
    while (ov_v != 4'hF && t < 40) begin
      step();
      t++;
    end
    check("bp_all_valid", 0, 32'(ov_v), 32'hF);
    repeat (10) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;

    // Reset in the second CALC cycle drops the in-flight result.
    issue(48'h0, 48'h0, 32'hD8D8DBBC);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(48'h0, 48'h0, 32'hD8D8DBBC);
    wait_idle("drain_after_reset");

    // Random traffic with in_valid held high and random backpressure.
    for (int i = 0; i < 300; i++) begin
      expand_data = {16'($urandom), $urandom};
      subkey      = {16'($urandom), $urandom};
      in_valid    = 1'b1;
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("drain_random");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_f_sbox_round.md
Name: des_f_sbox_round

Overview:
- Consumes the 48-bit expanded right half produced by the DES expansion stage.
- XORs it with the 48-bit round subkey, runs the eight DES S-boxes (S1..S8), applies the DES P permutation and returns the 32-bit f-function result.
- The S-boxes are time-multiplexed, LANES per cycle, to trade latency for area.
- Sits between the expansion stage and the Feistel left-half XOR in the round datapath.

Parameters:
- LANES, 2, S-boxes evaluated per cycle. Legal values are 1, 2, 4, 8. CALC lasts NCYC = 8/LANES cycles.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  expand_data/subkey valid.
- in_ready  out  1  block can accept a new operand.
- expand_data  in  48  expanded R; bit [47] = DES bit 1, bit [0] = DES bit 48.
- subkey  in  48  round key Kn, same bit ordering.
- out_valid  out  1  f_out valid.
- out_ready  in  1  consumer accepts f_out.
- f_out  out  32  f(R,K); bit [31] = DES bit 1.

Behaviour:
- Reset (sampled on the edge):
  - state goes to IDLE; lane counter = 0; x_reg, s_acc and f_out = 0; out_valid = 0.
  - in_ready = 0 while Reset is high, else it is 1 exactly when state == IDLE.
  - Reset overrides everything, including mid-CALC or DONE; the in-flight result is discarded with no output pulse.
- IDLE:
  - in_ready = 1.
  - On in_valid and in_ready: x_reg <= expand_data ^ subkey; cnt <= 0; s_acc <= 0; go to CALC.
  - Inputs are only sampled at this handshake edge.
- CALC:
  - in_ready = 0; out_valid = 0.
  - Each cycle takes the top LANES 6-bit groups of x_reg (S1 group = x_reg[47:42]).
  - For each group b1..b6: row = {b1,b6}, col = {b2,b3,b4,b5}; the 4-bit lookup uses the FIPS 46-3 S-box tables.
  - s_acc <= {s_acc[31-4*LANES:0], nibbles}, with the lower-numbered S-box more significant.
  - x_reg <= x_reg << 6*LANES.
  - cnt increments. When cnt == NCYC-1: f_out <= P(s_acc_next), out_valid <= 1, go to DONE.
- P permutation: f_out DES bit i = S-layer bit P[i], with P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
- DONE:
  - out_valid = 1, in_ready = 0; f_out is held stable until the handshake.
  - On out_ready: out_valid <= 0, go to IDLE.
  - No same-cycle accept of a new input; minimum initiation interval = NCYC + 2 cycles.
- Latency:
  - Handshake at edge E0 gives out_valid high after edge E0+NCYC (LANES=2: 4 edges).
  - out_ready asserted continuously means out_valid lasts exactly 1 cycle.
- Boundaries:
  - out_ready high while out_valid is 0 has no effect.
  - in_valid held high in CALC/DONE is ignored, with no queueing.
  - cnt width is clog2(NCYC), min 1 bit. For LANES=8, CALC lasts exactly 1 cycle.
- Purely combinational S-box ROMs. No X propagation from the unused ROM path when state != CALC; the registers simply do not load.

Test Plan:
- Reset and idle: assert Reset for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, f_out=0 during reset; in_ready=1 the cycle after release; no accept during reset.
- Zero vector, LANES=2: expand_data=0, subkey=0 -> S-layer EFA72C4D; f_out=D8D8DBBC; out_valid rises 4 edges after accept.
- Round-1 FIPS vector: expand_data=7A15557A1555, subkey=1B02EFFC7072 -> XOR 6117BA866527; S-layer 5C82B597; f_out=234AA9BB.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> f_out=234AA9BB stable, out_valid=1, in_ready=0 throughout. Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-CALC: assert Reset on the 2nd CALC cycle -> out_valid never pulses; a follow-up zero vector yields D8D8DBBC with normal latency.
- Parameter sweep: run both vectors back-to-back with LANES=1, 4, 8 -> identical f_out values; out_valid after 8, 2, 1 edges respectively; in_valid held high is accepted only in IDLE.
